// File: rtl/rtc_uart_frame_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rtc_uart_frame_ctrl_pkg
// Brief   : Shared types and constants for the RTC-to-UART frame sequencer:
//           FSM state encoding, ASCII constants, frame length and slot decode.
// Revision: 1.0 - initial release
// ============================================================================
package rtc_uart_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SEND  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5,
    ST_ABORT = 3'd6
  } state_t;

  // Kind of byte carried by each position of "HH:MM:SS\r\n"
  typedef enum logic [1:0] {
    SLOT_DIGIT = 2'd0,
    SLOT_COLON = 2'd1,
    SLOT_CR    = 2'd2,
    SLOT_LF    = 2'd3
  } slot_t;

  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  localparam int         FRAME_LEN = 10;
  localparam logic [3:0] LAST_IDX  = 4'(FRAME_LEN - 1);

  // Map a frame position to the kind of byte it carries
  function automatic slot_t frame_slot(input logic [3:0] idx);
    slot_t s;
    case (idx)
      4'd2, 4'd5: s = SLOT_COLON;
      4'd8:       s = SLOT_CR;
      4'd9:       s = SLOT_LF;
      default:    s = SLOT_DIGIT;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_uart_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : rtc_uart_frame_ctrl_if
// Brief   : Request/time inputs and byte-transmitter handshake of the frame
//           sequencer. master = requester + transmitter side, slave = sequencer.
// Revision: 1.0 - initial release
// ============================================================================
interface rtc_uart_frame_ctrl_if;
  logic       start;
  logic [7:0] hour_bcd;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       byte_send_en;
  logic [7:0] byte_data;
  logic       byte_tx_done;
  logic       busy;
  logic       frame_done;
  logic       err_timeout;

  modport master (
    output start, hour_bcd, min_bcd, sec_bcd, byte_tx_done,
    input  byte_send_en, byte_data, busy, frame_done, err_timeout
  );

  modport slave (
    input  start, hour_bcd, min_bcd, sec_bcd, byte_tx_done,
    output byte_send_en, byte_data, busy, frame_done, err_timeout
  );
endinterface
`default_nettype wire

// File: rtl/rtc_uart_frame_ctrl_bcd_digit_ascii.sv
`default_nettype none
// ============================================================================
// Module  : bcd_digit_ascii
// Brief   : One BCD nibble to its ASCII digit; non-decimal nibbles become '?'.
// Revision: 1.0 - initial release
// ============================================================================
module bcd_digit_ascii
  import rtc_uart_frame_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // 0..9 map onto '0'..'9'; A..F are reported as '?'
  always_comb begin
    ascii = ASCII_QMARK;
    if (nibble <= 4'd9) ascii = ASCII_ZERO + {4'd0, nibble};
  end

endmodule
`default_nettype wire

// File: rtl/rtc_uart_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : rtc_uart_frame_ctrl
// Brief   : Snapshots BCD hh/mm/ss on start and streams "HH:MM:SS\r\n" to a
//           byte transmitter, with an inter-byte gap and a tx_done watchdog.
// Revision: 1.0 - initial release
// ============================================================================
module rtc_uart_frame_ctrl
  import rtc_uart_frame_ctrl_pkg::*;
#(
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int CNT_W       = 20
) (
  input  logic                  clk,
  input  logic                  rstn,
  rtc_uart_frame_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       idx;
  logic [7:0]       snap_hour, snap_min, snap_sec;
  logic             send_en_q, busy_q, done_q, err_q;
  logic [7:0]       data_q;

  logic             tx_ok, timeout_hit, gap_end;
  logic [3:0]       nib;
  logic [7:0]       digit_ascii;
  logic [7:0]       next_byte;
  slot_t            slot;

  // tx_done only counts in WAIT, and beats a timeout landing on the same cycle
  assign tx_ok       = (state == ST_WAIT) && bus.byte_tx_done;
  assign timeout_hit = (state == ST_WAIT) && !bus.byte_tx_done && (cnt == TIMEOUT_LAST);
  assign gap_end     = (state == ST_GAP) && (cnt == GAP_LAST);

  // Nibble for the byte about to be sent; in LOAD the snapshot is not yet
  // valid, so byte 0 (hour tens) comes straight from the live input.
  always_comb begin
    nib = 4'h0;
    if (state == ST_LOAD) begin
      nib = bus.hour_bcd[7:4];
    end else begin
      case (idx)
        4'd0:    nib = snap_hour[7:4];
        4'd1:    nib = snap_hour[3:0];
        4'd3:    nib = snap_min[7:4];
        4'd4:    nib = snap_min[3:0];
        4'd6:    nib = snap_sec[7:4];
        4'd7:    nib = snap_sec[3:0];
        default: nib = 4'h0;
      endcase
    end
  end

  bcd_digit_ascii u_digit (
    .nibble (nib),
    .ascii  (digit_ascii)
  );

  // Select digit or punctuation for the byte about to be sent
  always_comb begin
    slot = (state == ST_LOAD) ? SLOT_DIGIT : frame_slot(idx);
    case (slot)
      SLOT_COLON: next_byte = ASCII_COLON;
      SLOT_CR:    next_byte = ASCII_CR;
      SLOT_LF:    next_byte = ASCII_LF;
      default:    next_byte = digit_ascii;
    endcase
  end

  // Frame sequencer; outputs are set on the edge that enters the state they belong to
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      send_en_q <= 1'b0;
      data_q    <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      send_en_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state  <= ST_LOAD;
            busy_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          state     <= ST_SEND;
          send_en_q <= 1'b1;
          data_q    <= next_byte;
        end
        ST_SEND: state <= ST_WAIT;
        ST_WAIT: begin
          if (tx_ok) begin
            if (idx == LAST_IDX) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else begin
              state <= ST_GAP;
            end
          end else if (timeout_hit) begin
            state <= ST_ABORT;
            err_q <= 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_end) begin
            state     <= ST_SEND;
            send_en_q <= 1'b1;
            data_q    <= next_byte;
          end
        end
        ST_DONE, ST_ABORT: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Shared gap/watchdog counter: cleared outside WAIT/GAP, saturating inside
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (tx_ok)               cnt <= '0;
          else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        end
        ST_GAP: begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Byte index and time snapshot; inputs are only looked at in LOAD
  always_ff @(posedge clk) begin
    if (!rstn) begin
      idx       <= 4'd0;
      snap_hour <= 8'h00;
      snap_min  <= 8'h00;
      snap_sec  <= 8'h00;
    end else if (state == ST_LOAD) begin
      idx       <= 4'd0;
      snap_hour <= bus.hour_bcd;
      snap_min  <= bus.min_bcd;
      snap_sec  <= bus.sec_bcd;
    end else if (tx_ok && (idx != LAST_IDX)) begin
      idx <= idx + 4'd1;
    end
  end

  assign bus.byte_send_en = send_en_q;
  assign bus.byte_data    = data_q;
  assign bus.busy         = busy_q;
  assign bus.frame_done   = done_q;
  assign bus.err_timeout  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rtc_uart_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_rtc_uart_frame_ctrl
// Brief   : Directed self-checking bench for rtc_uart_frame_ctrl with a
//           byte-transmitter model answering tx_done a set latency after send.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rtc_uart_frame_ctrl;

  logic clk;
  logic rstn;

  rtc_uart_frame_ctrl_if bus ();

  rtc_uart_frame_ctrl #(
    .GAP_CYC     (2),
    .TIMEOUT_CYC (50),
    .CNT_W       (20)
  ) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controls written only by the stimulus process
  int   n_lat      = 20;
  int   drop_idx   = -1;
  bit   clr_req    = 1'b0;
  bit   force_done = 1'b0;

  // State written only by the transmitter model
  int         cyc = 0;
  int         nsent, nframe, nerr, overlap, unstable, t_err, cd;
  bit         pend, drop_now;
  logic [7:0] cur;
  logic [7:0] got_bytes [0:15];
  int         t_send    [0:15];

  int n_checks = 0;
  int n_pass   = 0;

  // Transmitter model and event log, evaluated mid-cycle
  always @(negedge clk) begin
    cyc++;
    bus.byte_tx_done = force_done;
    if (clr_req) begin
      nsent = 0; nframe = 0; nerr = 0; overlap = 0; unstable = 0;
      t_err = 0; pend = 1'b0; cd = 0;
    end else begin
      if (pend && !bus.byte_send_en && (bus.byte_data !== cur)) unstable++;
      if (pend) begin
        if (cd <= 1) begin
          pend = 1'b0;
          if (!drop_now) bus.byte_tx_done = 1'b1;
        end else begin
          cd--;
        end
      end
      if (bus.byte_send_en) begin
        if (pend) overlap++;
        if (nsent < 16) begin
          got_bytes[nsent] = bus.byte_data;
          t_send[nsent]    = cyc;
        end
        drop_now = (nsent == drop_idx);
        cur      = bus.byte_data;
        pend     = 1'b1;
        cd       = n_lat;
        nsent++;
      end
      if (bus.frame_done) nframe++;
      if (bus.err_timeout) begin
        nerr++;
        t_err = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    bus.hour_bcd = h;
    bus.min_bcd  = m;
    bus.sec_bcd  = s;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (bus.busy && (k < budget)) begin
      tick();
      k++;
    end
    check({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic check_frame(input string tag, input logic [79:0] exp);
    for (int i = 0; i < 10; i++)
      check($sformatf("%s_b%0d", tag, i), {24'd0, got_bytes[i]}, {24'd0, exp[79-8*i -: 8]});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {31'd0, bus.busy},         32'd0);
    check({tag, "_send"}, {31'd0, bus.byte_send_en}, 32'd0);
    check({tag, "_data"}, {24'd0, bus.byte_data},    32'd0);
    check({tag, "_done"}, {31'd0, bus.frame_done},   32'd0);
    check({tag, "_err"},  {31'd0, bus.err_timeout},  32'd0);
  endtask

  initial begin
    int c;
    rstn      = 1'b0;
    bus.start = 1'b0;
    set_time(8'h00, 8'h00, 8'h00);
    clear_log();
    repeat (3) tick();
    check_reset_outputs("rst");
    rstn = 1'b1;
    tick();

    // T1: basic frame 12:34:56, start latency and inter-byte spacing
    set_time(8'h12, 8'h34, 8'h56);
    n_lat = 20;
    clear_log();
    pulse_start();
    check("t1_busy_load", {31'd0, bus.busy}, 32'd1);
    tick();
    check("t1_first_send", {31'd0, bus.byte_send_en}, 32'd1);
    check("t1_first_data", {24'd0, bus.byte_data}, 32'h31);
    wait_idle("t1", 600);
    check("t1_nsent", nsent, 10);
    check("t1_nframe", nframe, 1);
    check("t1_nerr", nerr, 0);
    check("t1_overlap", overlap, 0);
    check("t1_unstable", unstable, 0);
    check("t1_spacing", t_send[1] - t_send[0], 23);
    check_frame("t1", 80'h31_32_3A_33_34_3A_35_36_0D_0A);

    // T2: extra starts while busy are dropped; mid-frame input changes ignored
    set_time(8'h07, 8'h08, 8'h09);
    clear_log();
    bus.start = 1'b1;
    c = 0;
    while (c < 800) begin
      tick();
      c++;
      bus.start = (c == 5) || (c == 30) || (c == 60);
      if (c == 40) set_time(8'h99, 8'h99, 8'h99);
      if (!bus.busy && (c > 3)) break;
    end
    bus.start = 1'b0;
    check("t2_idle", {31'd0, bus.busy}, 32'd0);
    repeat (5) tick();
    check("t2_nsent", nsent, 10);
    check("t2_nframe", nframe, 1);
    check_frame("t2", 80'h30_37_3A_30_38_3A_30_39_0D_0A);

    // T3: transmitter never completes byte 3 -> watchdog abort
    set_time(8'h12, 8'h34, 8'h56);
    drop_idx = 3;
    clear_log();
    pulse_start();
    wait_idle("t3", 600);
    check("t3_nerr", nerr, 1);
    check("t3_nframe", nframe, 0);
    check("t3_nsent", nsent, 4);
    check("t3_err_time", t_err - t_send[3], 51);
    check("t3_data_hold", {24'd0, bus.byte_data}, 32'h33);
    drop_idx = -1;

    // T4: non-decimal nibble and zero hour, also proves recovery after abort
    set_time(8'h00, 8'h34, 8'h5A);
    clear_log();
    pulse_start();
    wait_idle("t4", 600);
    check("t4_nsent", nsent, 10);
    check("t4_nframe", nframe, 1);
    check_frame("t4", 80'h30_30_3A_33_34_3A_35_3F_0D_0A);

    // T5: reset during byte 4 WAIT, then stray tx_done in IDLE
    set_time(8'h12, 8'h34, 8'h56);
    clear_log();
    pulse_start();
    c = 0;
    while ((nsent < 5) && (c < 300)) begin
      tick();
      c++;
    end
    check("t5_reach_b4", nsent, 5);
    repeat (3) tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check_reset_outputs("t5");
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    repeat (60) tick();
    check("t5_busy", {31'd0, bus.busy}, 32'd0);
    check("t5_nsent", nsent, 5);
    check("t5_nframe", nframe, 0);
    check("t5_nerr", nerr, 0);

    // T6: tx_done on the last watchdog cycle wins; one cycle later aborts
    n_lat = 50;
    clear_log();
    pulse_start();
    wait_idle("t6a", 1000);
    check("t6a_nsent", nsent, 10);
    check("t6a_nframe", nframe, 1);
    check("t6a_nerr", nerr, 0);
    check("t6a_overlap", overlap, 0);
    n_lat = 51;
    clear_log();
    pulse_start();
    wait_idle("t6b", 300);
    repeat (5) tick();
    check("t6b_nerr", nerr, 1);
    check("t6b_nframe", nframe, 0);
    check("t6b_nsent", nsent, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end

endmodule
`default_nettype wire
